lag_pair_gen: RTL and testbench

- Upstream feeder for the 64-sample complex lag-correlation MAC.
- Buffers one frame of FRAME+LAG complex input samples from a valid/ready stream.
- Then streams FRAME consecutive pairs (x[i], x[i+LAG]) with a continuous enable, so the MAC runs one uninterrupted accumulation window per frame.
- Enable drops between frames, which clears the MAC for the next window.

---
 rtl/lag_pair_gen_pkg.sv | 19 +
 rtl/lag_sample_ram.sv | 27 ++
 rtl/lag_pair_gen.sv | 109 ++++++++++
 tb/tb_lag_pair_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lag_pair_gen_pkg.sv
// Shared sizes and types for the lag-pair feeder in front of the 64-sample lag-correlation MAC.
// Defaults match the MAC window; the complex sample type packs {re, im}.
package lag_pair_gen_pkg;

  localparam int CPLX_DW   = 16;
  localparam int MAC_FRAME = 64;
  localparam int MAC_LAG   = 4;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_t;

  typedef struct packed {
    logic signed [CPLX_DW-1:0] re;
    logic signed [CPLX_DW-1:0] im;
  } cplx_t;

endpackage

// File: rtl/lag_sample_ram.sv
// Frame buffer: one synchronous write port, two asynchronous read ports.
// Zero read latency; no flow control of its own, the owner sequences all accesses.
module lag_sample_ram #(
  parameter int W     = 32,
  parameter int DEPTH = 68,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [W-1:0]  rdata_a,
  output logic [W-1:0]  rdata_b
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/lag_pair_gen.sv
// Buffers FRAME+LAG samples, then emits FRAME gap-free (x[i], x[i+LAG]) pairs with mac_en; launch is 2 edges after the last accept.
// in_ready is low from the cycle after the last accept until the last pair is on the outputs; a held sample waits.
module lag_pair_gen
  import lag_pair_gen_pkg::*;
#(
  parameter int DW    = CPLX_DW,
  parameter int LAG   = MAC_LAG,
  parameter int FRAME = MAC_FRAME
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          mac_en,
  output logic [DW-1:0] xn_re,
  output logic [DW-1:0] xn_im,
  output logic [DW-1:0] xn4_re,
  output logic [DW-1:0] xn4_im,
  output logic          frame_done
);

  localparam int DEPTH = FRAME + LAG;
  localparam int AW    = $clog2(DEPTH);
  localparam int RW    = $clog2(FRAME);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_cnt;
  logic [RW-1:0] rd_cnt;
  logic          rd_go;
  logic          accept, wr_last, rd_issue, rd_last;
  logic [AW-1:0] raddr_a, raddr_b;
  logic [2*DW-1:0] rdata_a, rdata_b;

  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == FILL);
    accept   = in_valid && in_ready;
    wr_last  = (wr_cnt == AW'(DEPTH - 1));
    rd_issue = (state_q == STREAM) && rd_go;
    rd_last  = rd_issue && (rd_cnt == RW'(FRAME - 1));
    case (state_q)
      FILL:    if (accept && wr_last) state_d = STREAM;
      STREAM:  if (rd_last) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // The first STREAM cycle only arms the reader, so pair 0 lands two edges after
  // the final accept and the idle gap between windows covers a whole refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      rd_go  <= 1'b0;
    end else begin
      if (accept) wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
      if (rd_issue) rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
      if (state_q == STREAM && !rd_go) rd_go <= 1'b1;
      else if (rd_last)                rd_go <= 1'b0;
    end
  end

  assign raddr_a = AW'(rd_cnt);
  assign raddr_b = AW'(rd_cnt) + AW'(LAG);

  lag_sample_ram #(
    .W     (2 * DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we      (accept),
    .waddr   (wr_cnt),
    .wdata   ({in_re, in_im}),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  // Data registers load only on issue, so they hold the last pair between frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_en     <= 1'b0;
      frame_done <= 1'b0;
      xn_re      <= '0;
      xn_im      <= '0;
      xn4_re     <= '0;
      xn4_im     <= '0;
    end else begin
      mac_en     <= rd_issue;
      frame_done <= rd_last;
      if (rd_issue) begin
        xn_re  <= rdata_a[2*DW-1:DW];
        xn_im  <= rdata_a[DW-1:0];
        xn4_re <= rdata_b[2*DW-1:DW];
        xn4_im <= rdata_b[DW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_lag_pair_gen.sv
// Randomized bench for lag_pair_gen against a frame-level queue model of fill, launch delay and pair emission.
// Covers reset, ramps, gapped input, held-sample backpressure, mid-stream reset and full-scale extremes.
module tb_lag_pair_gen;
  import lag_pair_gen_pkg::*;

  localparam int DW    = CPLX_DW;
  localparam int LAG   = MAC_LAG;
  localparam int FRAME = MAC_FRAME;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_re, in_im;
  logic          mac_en, frame_done;
  logic [DW-1:0] xn_re, xn_im, xn4_re, xn4_im;

  lag_pair_gen #(.DW(DW), .LAG(LAG), .FRAME(FRAME)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_re      (in_re),
    .in_im      (in_im),
    .mac_en     (mac_en),
    .xn_re      (xn_re),
    .xn_im      (xn_im),
    .xn4_re     (xn4_re),
    .xn4_im     (xn4_im),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] z(input logic [DW-1:0] v);
    return 32'(v);
  endfunction

  // Reference model: a frame completes after FRAME+LAG accepts, then after one
  // dead edge its FRAME pairs come out one per edge; input is refused while any remain.
  cplx_t fill_q[$];
  cplx_t pend_xn[$];
  cplx_t pend_x4[$];
  int    launch_wait = 0;
  logic  exp_en = 1'b0, exp_done = 1'b0;
  cplx_t exp_xn = '0, exp_x4 = '0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        fill_q.delete();
        pend_xn.delete();
        pend_x4.delete();
        launch_wait = 0;
        exp_en = 1'b0;
        exp_done = 1'b0;
        exp_xn = '0;
        exp_x4 = '0;
      end else begin
        exp_en = 1'b0;
        exp_done = 1'b0;
        if (pend_xn.size() != 0) begin
          if (launch_wait > 0) launch_wait--;
          else begin
            exp_xn = pend_xn.pop_front();
            exp_x4 = pend_x4.pop_front();
            exp_en = 1'b1;
            exp_done = (pend_xn.size() == 0);
          end
        end else if (in_valid) begin
          cplx_t s;
          s.re = in_re;
          s.im = in_im;
          fill_q.push_back(s);
          if (fill_q.size() == FRAME + LAG) begin
            for (int i = 0; i < FRAME; i++) begin
              pend_xn.push_back(fill_q[i]);
              pend_x4.push_back(fill_q[i + LAG]);
            end
            fill_q.delete();
            launch_wait = 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison plus window-length and idle-gap tracking.
  logic prev_en = 1'b0;
  int   hi_run = 0, low_run = 0;
  bit   seen_win = 1'b0;

  initial begin
    forever begin
      @(posedge rst);
      prev_en = 1'b0;
      hi_run = 0;
      low_run = 0;
      seen_win = 1'b0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready",   32'(in_ready),   32'(pend_xn.size() == 0));
      chk("mac_en",     32'(mac_en),     32'(exp_en));
      chk("frame_done", 32'(frame_done), 32'(exp_done));
      chk("xn_re",  z(xn_re),  z(exp_xn.re));
      chk("xn_im",  z(xn_im),  z(exp_xn.im));
      chk("xn4_re", z(xn4_re), z(exp_x4.re));
      chk("xn4_im", z(xn4_im), z(exp_x4.im));
      if (!rst) begin
        if (mac_en) begin
          if (!prev_en && seen_win) chk("idle_gap_ge_fill", 32'(low_run >= FRAME + LAG), 32'd1);
          hi_run++;
        end else begin
          if (prev_en) begin
            chk("window_len", 32'(hi_run), 32'(FRAME));
            seen_win = 1'b1;
            hi_run = 0;
            low_run = 0;
          end
          low_run++;
        end
        prev_en = mac_en;
      end
    end
  end

  task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im);
    bit got = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_re = re;
    in_im = im;
    while (!got && n < 400) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after the final-accept edge: no pair on the next edge, pair 0 on the one after.
  task automatic launch_check(input string tag, input logic [DW-1:0] re0, input logic [DW-1:0] x4re0);
    chk({tag, "_en_e0"}, 32'(mac_en), 32'd0);
    idle(1);
    chk({tag, "_en_e1"}, 32'(mac_en), 32'd0);
    idle(1);
    chk({tag, "_en_e2"}, 32'(mac_en), 32'd1);
    chk({tag, "_p0_re"}, z(xn_re), z(re0));
    chk({tag, "_p0_x4re"}, z(xn4_re), z(x4re0));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (n < 300 && (pend_xn.size() != 0 || mac_en)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 32'd0, 32'd1);
    idle(2);
  endtask

  logic [DW-1:0] smp_re [FRAME+LAG];
  logic [DW-1:0] smp_im [FRAME+LAG];

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_re = '0;
    in_im = '0;
    idle(3);
    chk("rst_mac_en", 32'(mac_en), 32'd0);
    chk("rst_xn_re", z(xn_re), 32'd0);
    rst = 1'b0;
    idle(1);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_mac_en", 32'(mac_en), 32'd0);

    // Ramp, back-to-back valid
    for (int k = 0; k < FRAME + LAG; k++) send(DW'(k), DW'(-k));
    launch_check("ramp", DW'(0), DW'(LAG));
    wait_drain();

    // Same ramp with a bubble after every sample
    for (int k = 0; k < FRAME + LAG; k++) begin
      send(DW'(k), DW'(-k));
      if (k != FRAME + LAG - 1) idle(1);
    end
    launch_check("gap", DW'(0), DW'(LAG));
    wait_drain();

    // Random frame, then sample 100 held through the whole stream
    for (int k = 0; k < FRAME + LAG; k++) send(DW'($urandom), DW'($urandom));
    send(DW'(100), DW'(7));
    smp_re[LAG] = '0;
    for (int k = 1; k < FRAME + LAG; k++) begin
      smp_re[k] = DW'($urandom);
      send(smp_re[k], DW'($urandom));
    end
    launch_check("bp", DW'(100), smp_re[LAG]);
    wait_drain();

    // Reset while pair 20 is on the outputs
    for (int k = 0; k < FRAME + LAG; k++) send(DW'($urandom), DW'($urandom));
    idle(2 + 20);
    #3 rst = 1'b1;
    #1;
    chk("mrst_mac_en", 32'(mac_en), 32'd0);
    chk("mrst_done", 32'(frame_done), 32'd0);
    chk("mrst_xn_re", z(xn_re), 32'd0);
    chk("mrst_xn4_im", z(xn4_im), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < FRAME + LAG; k++) begin
      smp_re[k] = DW'($urandom);
      smp_im[k] = DW'($urandom);
      send(smp_re[k], smp_im[k]);
    end
    launch_check("mrst", smp_re[0], smp_re[LAG]);
    chk("mrst_p0_im", z(xn_im), z(smp_im[0]));
    wait_drain();

    // Full-scale alternation, two frames offered back to back
    for (int k = 0; k < 2 * (FRAME + LAG); k++) begin
      if (k % 2 == 0) send(DW'(16'h8000), DW'(16'h7fff));
      else            send(DW'(16'h7fff), DW'(16'h8000));
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
